// File: rtl/glyph_plotter.sv
`default_nettype none
// ============================================================================
// Module   : glyph_plotter
// Brief    : Scaled glyph renderer; fetches bitmap rows from an external ROM
//            and streams one pixel per cycle under valid/ready backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module glyph_plotter #(
    parameter int GLYPH_W  = 8,
    parameter int GLYPH_H  = 10,
    parameter int COORD_W  = 8,
    parameter int COLOUR_W = 6,
    parameter int CODE_W   = 6,
    parameter int SCALE_W  = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [CODE_W-1:0]          char_code,
    input  logic [COORD_W-1:0]         origin_x,
    input  logic [COORD_W-1:0]         origin_y,
    input  logic [SCALE_W-1:0]         scale_m1,
    input  logic [COLOUR_W-1:0]        fg_colour,
    input  logic [COLOUR_W-1:0]        bg_colour,
    input  logic                       opaque,
    output logic [CODE_W-1:0]          rom_code,
    output logic [$clog2(GLYPH_H)-1:0] rom_row,
    input  logic [GLYPH_W-1:0]         rom_bits,
    output logic [COORD_W-1:0]         plot_x,
    output logic [COORD_W-1:0]         plot_y,
    output logic [COLOUR_W-1:0]        plot_colour,
    output logic                       plot_valid,
    input  logic                       plot_ready,
    output logic                       busy,
    output logic                       done
);

    localparam int COL_W = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int ROW_W = $clog2(GLYPH_H);
    localparam logic [COL_W-1:0] c_last_col = COL_W'(GLYPH_W - 1);
    localparam logic [ROW_W-1:0] c_last_row = ROW_W'(GLYPH_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [CODE_W-1:0]     r_code;
    logic [ROW_W-1:0]      r_row;
    logic [SCALE_W-1:0]    r_sy;
    logic [COL_W-1:0]      r_col;
    logic [SCALE_W-1:0]    r_sx;
    logic [SCALE_W-1:0]    r_scale_m1;
    logic [COORD_W-1:0]    r_ox;
    logic [COORD_W-1:0]    r_oy;
    logic [COLOUR_W-1:0]   r_fg;
    logic [COLOUR_W-1:0]   r_bg;
    logic                  r_opaque;
    logic [GLYPH_W-1:0]    r_line;
    // Pixel offsets from the origin (c*S+sx, r*S+sy) kept as running counts
    logic [COORD_W-1:0]    r_xoff;
    logic [COORD_W-1:0]    r_yoff;
    logic [COORD_W-1:0]    r_plot_x;
    logic [COORD_W-1:0]    r_plot_y;
    logic [COLOUR_W-1:0]   r_plot_colour;
    logic                  r_plot_valid;

    logic                  w_advance;
    logic                  w_line_end;
    logic                  w_last_cell;
    logic [SCALE_W-1:0]    w_sx_next;
    logic [COL_W-1:0]      w_cell_col;
    logic [COORD_W-1:0]    w_cell_xoff;
    logic [GLYPH_W-1:0]    w_cell_bits;
    logic                  w_cell_bit;
    logic [COORD_W-1:0]    w_plot_x;
    logic [COORD_W-1:0]    w_plot_y;

    assign w_advance   = (r_state == S_EMIT) && (!r_plot_valid || plot_ready);
    assign w_line_end  = (r_col == c_last_col) && (r_sx == r_scale_m1);
    assign w_last_cell = w_line_end && (r_row == c_last_row) && (r_sy == r_scale_m1);
    assign w_sx_next   = (r_sx == r_scale_m1) ? '0 : r_sx + SCALE_W'(1);

    // In FETCH the first cell of the line is built straight from the ROM output
    always_comb begin
        w_cell_col  = '0;
        w_cell_xoff = '0;
        w_cell_bits = r_line;
        if (r_state == S_FETCH) begin
            w_cell_bits = rom_bits;
        end else begin
            w_cell_col  = (r_sx == r_scale_m1) ? r_col + COL_W'(1) : r_col;
            w_cell_xoff = r_xoff + COORD_W'(1);
        end
        w_cell_bit = w_cell_bits[c_last_col - w_cell_col];
    end

    assign w_plot_x = r_ox + w_cell_xoff;
    assign w_plot_y = r_oy + r_yoff;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_FETCH;
            S_FETCH: w_next_state = S_EMIT;
            S_EMIT:  if (w_advance && w_line_end)
                         w_next_state = w_last_cell ? S_DONE : S_FETCH;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_code        <= '0;
            r_row         <= '0;
            r_sy          <= '0;
            r_col         <= '0;
            r_sx          <= '0;
            r_scale_m1    <= '0;
            r_ox          <= '0;
            r_oy          <= '0;
            r_fg          <= '0;
            r_bg          <= '0;
            r_opaque      <= 1'b0;
            r_line        <= '0;
            r_xoff        <= '0;
            r_yoff        <= '0;
            r_plot_x      <= '0;
            r_plot_y      <= '0;
            r_plot_colour <= '0;
            r_plot_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_code     <= char_code;
                        r_ox       <= origin_x;
                        r_oy       <= origin_y;
                        r_scale_m1 <= scale_m1;
                        r_fg       <= fg_colour;
                        r_bg       <= bg_colour;
                        r_opaque   <= opaque;
                        r_row      <= '0;
                        r_sy       <= '0;
                        r_col      <= '0;
                        r_sx       <= '0;
                        r_xoff     <= '0;
                        r_yoff     <= '0;
                    end
                end
                S_FETCH: begin
                    r_line        <= rom_bits;
                    r_plot_valid  <= w_cell_bit | r_opaque;
                    r_plot_x      <= w_plot_x;
                    r_plot_y      <= w_plot_y;
                    r_plot_colour <= w_cell_bit ? r_fg : r_bg;
                end
                S_EMIT: begin
                    if (w_advance) begin
                        if (w_line_end) begin
                            r_plot_valid <= 1'b0;
                            r_col        <= '0;
                            r_sx         <= '0;
                            r_xoff       <= '0;
                            // Row index stays in range after the final line
                            if (!w_last_cell) begin
                                r_yoff <= r_yoff + COORD_W'(1);
                                if (r_sy == r_scale_m1) begin
                                    r_sy  <= '0;
                                    r_row <= r_row + ROW_W'(1);
                                end else begin
                                    r_sy  <= r_sy + SCALE_W'(1);
                                end
                            end
                        end else begin
                            r_col         <= w_cell_col;
                            r_sx          <= w_sx_next;
                            r_xoff        <= w_cell_xoff;
                            r_plot_valid  <= w_cell_bit | r_opaque;
                            r_plot_x      <= w_plot_x;
                            r_plot_y      <= w_plot_y;
                            r_plot_colour <= w_cell_bit ? r_fg : r_bg;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rom_code    = r_code;
    assign rom_row     = r_row;
    assign plot_x      = r_plot_x;
    assign plot_y      = r_plot_y;
    assign plot_colour = r_plot_colour;
    assign plot_valid  = r_plot_valid;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_glyph_plotter.sv
`default_nettype none
// ============================================================================
// Module   : tb_glyph_plotter
// Brief    : Self-checking bench for glyph_plotter against a pixel-list model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_glyph_plotter;

    localparam int GW = 8;
    localparam int GH = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  char_code = '0;
    logic [7:0]  origin_x = '0;
    logic [7:0]  origin_y = '0;
    logic [1:0]  scale_m1 = '0;
    logic [5:0]  fg_colour = '0;
    logic [5:0]  bg_colour = '0;
    logic        opaque = 1'b0;
    logic [5:0]  rom_code;
    logic [3:0]  rom_row;
    logic [7:0]  rom_bits;
    logic [7:0]  plot_x;
    logic [7:0]  plot_y;
    logic [5:0]  plot_colour;
    logic        plot_valid;
    logic        plot_ready = 1'b1;
    logic        busy;
    logic        done;

    glyph_plotter #(
        .GLYPH_W(GW), .GLYPH_H(GH), .COORD_W(8), .COLOUR_W(6), .CODE_W(6), .SCALE_W(2)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .char_code(char_code),
        .origin_x(origin_x), .origin_y(origin_y), .scale_m1(scale_m1),
        .fg_colour(fg_colour), .bg_colour(bg_colour), .opaque(opaque),
        .rom_code(rom_code), .rom_row(rom_row), .rom_bits(rom_bits),
        .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
        .plot_valid(plot_valid), .plot_ready(plot_ready), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    logic [7:0]  rom_mem [0:64*GH-1];
    assign rom_bits = (rom_row < 4'(GH)) ? rom_mem[int'(rom_code)*GH + int'(rom_row)] : 8'h00;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [21:0] exp_q [$];
    bit          exp_first_vis;
    int          exp_lat;
    bit          bp_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Expected pixel list: every cell of the scaled glyph in raster order
    task automatic build_model(input int code, input int ox, input int oy, input int sm1,
                               input int fg, input int bg, input bit opq);
        int s;
        logic [7:0] bits;
        logic [7:0] px;
        logic [7:0] py;
        bit b;
        s = sm1 + 1;
        for (int r = 0; r < GH; r++)
            for (int sy = 0; sy < s; sy++)
                for (int c = 0; c < GW; c++)
                    for (int sx = 0; sx < s; sx++) begin
                        bits = rom_mem[code*GH + r];
                        b    = bits[GW-1-c];
                        if (b || opq) begin
                            px = 8'((ox + c*s + sx) % 256);
                            py = 8'((oy + r*s + sy) % 256);
                            exp_q.push_back({px, py, b ? 6'(fg) : 6'(bg)});
                        end
                    end
        bits          = rom_mem[code*GH];
        exp_first_vis = bits[GW-1] || opq;
        exp_lat       = GH*s*(1 + GW*s) + 1;
    endtask

    task automatic start_req(input int code, input int ox, input int oy, input int sm1,
                             input int fg, input int bg, input bit opq);
        @(negedge clock);
        char_code = 6'(code);
        origin_x  = 8'(ox);
        origin_y  = 8'(oy);
        scale_m1  = 2'(sm1);
        fg_colour = 6'(fg);
        bg_colour = 6'(bg);
        opaque    = opq;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        build_model(code, ox, oy, sm1, fg, bg, opq);
    endtask

    task automatic wait_done(input bit check_lat, input bit poke);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 5000) begin
            @(negedge clock);
            cyc++;
            start = 1'b0;
            if (cyc == 1) begin
                chk("busy_after_accept", busy, 1);
                chk("valid_in_fetch", plot_valid, 0);
            end
            if (cyc == 2) chk("first_valid", plot_valid, exp_first_vis);
            if (poke && cyc == 5) begin
                start     = 1'b1;
                char_code = 6'd1;
                origin_x  = 8'd99;
                opaque    = ~opaque;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk("done_timeout", 0, 1);
        end else begin
            if (check_lat) chk("latency", cyc, exp_lat);
            chk("queue_drained", exp_q.size(), 0);
            @(negedge clock);
            chk("busy_after_done", busy, 0);
            chk("done_one_cycle", done, 0);
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            plot_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Pixel scoreboard plus hold-while-stalled check
    initial begin
        logic [21:0] prev_px;
        bit prev_stall;
        prev_stall = 1'b0;
        prev_px    = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    chk("stall_hold", {plot_valid, plot_x, plot_y, plot_colour}, {1'b1, prev_px});
                if (plot_valid && plot_ready) begin
                    if (exp_q.size() == 0) chk("extra_pixel", exp_q.size(), 1);
                    else chk("pixel", {plot_x, plot_y, plot_colour}, exp_q.pop_front());
                end
                prev_stall = plot_valid && !plot_ready;
                prev_px    = {plot_x, plot_y, plot_colour};
            end
        end
    end

    initial begin
        for (int i = 0; i < 64*GH; i++) rom_mem[i] = 8'($urandom);
        for (int r = 0; r < GH; r++) begin
            rom_mem[1*GH + r] = 8'h81;
            rom_mem[2*GH + r] = 8'h00;
            rom_mem[3*GH + r] = 8'hFF;
        end
        rom_mem[2*GH] = 8'h80;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("reset_busy", busy, 0);
        chk("reset_valid", plot_valid, 0);
        chk("reset_done", done, 0);
        chk("reset_xy", {plot_x, plot_y, plot_colour}, 0);
        chk("reset_rom", {rom_code, rom_row}, 0);

        // Opaque 8'b10000001 glyph, S=1
        start_req(1, 10, 20, 0, 6'h2A, 6'h15, 1'b1);
        chk("model_opaque_count", exp_q.size(), 80);
        chk("model_opaque_p0", exp_q[0], {8'd10, 8'd20, 6'h2A});
        chk("model_opaque_p1", exp_q[1], {8'd11, 8'd20, 6'h15});
        chk("model_opaque_p7", exp_q[7], {8'd17, 8'd20, 6'h2A});
        chk("model_lat_s1", exp_lat, 91);
        wait_done(1'b1, 1'b0);

        // Same glyph, transparent
        start_req(1, 10, 20, 0, 6'h2A, 6'h15, 1'b0);
        chk("model_transp_count", exp_q.size(), 20);
        chk("model_transp_p1", exp_q[1], {8'd17, 8'd20, 6'h2A});
        wait_done(1'b1, 1'b0);

        // S=2 single pixel
        start_req(2, 4, 4, 1, 6'h3F, 6'h01, 1'b0);
        chk("model_s2_count", exp_q.size(), 4);
        chk("model_s2_p0", exp_q[0], {8'd4, 8'd4, 6'h3F});
        chk("model_s2_p1", exp_q[1], {8'd5, 8'd4, 6'h3F});
        chk("model_s2_p2", exp_q[2], {8'd4, 8'd5, 6'h3F});
        chk("model_s2_p3", exp_q[3], {8'd5, 8'd5, 6'h3F});
        chk("model_lat_s2", exp_lat, 341);
        wait_done(1'b1, 1'b0);

        // X wrap-around with a start pulse while busy
        start_req(3, 252, 40, 0, 6'h07, 6'h00, 1'b0);
        chk("model_wrap_x0", exp_q[0][21:14], 252);
        chk("model_wrap_x3", exp_q[3][21:14], 255);
        chk("model_wrap_x4", exp_q[4][21:14], 0);
        chk("model_wrap_x7", exp_q[7][21:14], 3);
        wait_done(1'b1, 1'b1);

        // Reset mid-glyph, then a fresh draw
        start_req(8, 30, 30, 1, 6'h11, 6'h22, 1'b1);
        repeat (30) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("midreset_busy", busy, 0);
        chk("midreset_valid", plot_valid, 0);
        chk("midreset_x", plot_x, 0);
        chk("midreset_rest", {plot_y, plot_colour, rom_code, rom_row, done}, 0);
        start_req(9, 100, 200, 0, 6'h05, 6'h0A, 1'b1);
        wait_done(1'b1, 1'b0);

        // Backpressure replay of the opaque glyph
        bp_mode = 1'b1;
        start_req(1, 10, 20, 0, 6'h2A, 6'h15, 1'b1);
        wait_done(1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            bp_mode = (i % 2) == 1;
            start_req($urandom_range(8, 15), $urandom_range(0, 255), $urandom_range(0, 255),
                      $urandom_range(0, 3), $urandom_range(0, 63), $urandom_range(0, 63),
                      1'($urandom_range(0, 1)));
            wait_done(!bp_mode, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
